// File: rtl/simmem_release_scheduler.sv
// Release scheduler for one response bank: serialises the multi-hot release-enable vector into
// single valid/ready offers using a round-robin pick, and confirms each accepted release.
module simmem_release_scheduler #(
    parameter int unsigned Capa = 16,
    parameter int unsigned IidW = $clog2(Capa),
    parameter int unsigned CntW = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [Capa-1:0] release_en_mhot_i,
    input  logic            rsp_ready_i,
    output logic            rsp_valid_o,
    output logic [Capa-1:0] release_iid_onehot_o,
    output logic [IidW-1:0] release_iid_o,
    output logic [Capa-1:0] released_iid_onehot_o,
    output logic [CntW-1:0] release_cnt_o
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StOffer = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [Capa-1:0] grant_q, grant_d;
    logic [IidW-1:0] rr_q, rr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            offering;
    logic            handshake;
    logic [IidW-1:0] grant_idx;
    logic [IidW-1:0] rr_next;
    logic [IidW-1:0] search_start;
    logic [Capa-1:0] eligible;
    logic [Capa-1:0] pick_onehot;
    logic            pick_found;

    assign offering  = (state_q == StOffer);
    assign handshake = offering && rsp_ready_i;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < Capa; i++) begin
            if (grant_q[i]) begin
                grant_idx = grant_idx | IidW'(i);
            end
        end
    end

    // Capa is a power of two, so the increment wraps Capa-1 -> 0 by itself.
    assign rr_next = grant_idx + IidW'(1);

    // While offering, the pick only matters on a handshake, where the just-granted IID must
    // not win again even if its enable is still high.
    assign search_start = offering ? rr_next : rr_q;
    assign eligible     = offering ? (release_en_mhot_i & ~grant_q) : release_en_mhot_i;

    // Single-cycle rotating priority search starting at search_start.
    always_comb begin
        logic [IidW-1:0] idx;
        pick_onehot = '0;
        pick_found  = 1'b0;
        idx         = '0;
        for (int i = 0; i < Capa; i++) begin
            idx = search_start + IidW'(i);
            if (!pick_found && eligible[idx]) begin
                pick_onehot[idx] = 1'b1;
                pick_found       = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_onehot;
                    state_d = StOffer;
                end
            end
            StOffer: begin
                if (rsp_ready_i) begin
                    cnt_d = cnt_q + CntW'(1);
                    rr_d  = rr_next;
                    if (pick_found) begin
                        grant_d = pick_onehot;
                    end else begin
                        grant_d = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid_o           = offering;
    assign release_iid_onehot_o  = offering ? grant_q : '0;
    assign release_iid_o         = offering ? grant_idx : '0;
    assign released_iid_onehot_o = handshake ? grant_q : '0;
    assign release_cnt_o         = cnt_q;

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Bench for simmem_release_scheduler: directed vector table, hand-written corner sequences and
// random traffic checked against an index-level round-robin model.
module tb_simmem_release_scheduler;

    localparam int Capa = 16;
    localparam int IidW = 4;
    localparam int CntW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [Capa-1:0] en;
    logic            rdy;
    logic            valid;
    logic [Capa-1:0] offer_oh;
    logic [IidW-1:0] offer_iid;
    logic [Capa-1:0] rel_oh;
    logic [CntW-1:0] cnt;

    always #5 clk = ~clk;

    simmem_release_scheduler #(
        .Capa(Capa),
        .IidW(IidW),
        .CntW(CntW)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .release_en_mhot_i     (en),
        .rsp_ready_i           (rdy),
        .rsp_valid_o           (valid),
        .release_iid_onehot_o  (offer_oh),
        .release_iid_o         (offer_iid),
        .released_iid_onehot_o (rel_oh),
        .release_cnt_o         (cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: "offering IID m_gnt" or nothing, next-search start m_rr, accepted count m_cnt.
    bit          m_off;
    int          m_gnt;
    int          m_rr;
    logic [31:0] m_cnt;

    typedef struct {
        logic        rst;
        logic [15:0] en;
        logic        rdy;
        logic        val;
        logic [3:0]  iid;
        logic [15:0] rel;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [15:0] v, input int start);
        for (int i = 0; i < Capa; i++) begin
            int k;
            k = (start + i) % Capa;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_off = 0;
        m_gnt = 0;
        m_rr  = 0;
        m_cnt = 0;
    endtask

    task automatic model_clock(input logic [15:0] e, input logic r);
        logic [15:0] elig;
        if (!m_off) begin
            if (e != 0) begin
                m_gnt = pick(e, m_rr);
                m_off = 1;
            end
        end else if (r) begin
            m_cnt = m_cnt + 1;
            m_rr  = (m_gnt + 1) % Capa;
            elig  = e & ~(16'h1 << m_gnt);
            if (elig != 0) m_gnt = pick(elig, m_rr);
            else m_off = 0;
        end
    endtask

    task automatic check_model(input string tag);
        logic [15:0] oh;
        oh = m_off ? (16'h1 << m_gnt) : 16'h0;
        chk({tag, ".valid"}, {31'h0, valid}, {31'h0, m_off});
        chk({tag, ".offer_oh"}, {16'h0, offer_oh}, {16'h0, oh});
        chk({tag, ".iid"}, {28'h0, offer_iid}, m_off ? m_gnt : 0);
        chk({tag, ".released"}, {16'h0, rel_oh}, {16'h0, (m_off && rdy) ? oh : 16'h0});
        chk({tag, ".cnt"}, cnt, m_cnt);
    endtask

    // Entered and left at posedge+1.
    task automatic do_reset();
        rst_n = 1'b0;
        en    = '0;
        rdy   = 1'b0;
        #2;
        chk("rst.valid", {31'h0, valid}, 0);
        chk("rst.released", {16'h0, rel_oh}, 0);
        chk("rst.cnt", cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic [15:0] e, input logic r, input string tag);
        en  = e;
        rdy = r;
        #4;
        check_model(tag);
        @(posedge clk);
        model_clock(e, r);
        #1;
    endtask

    task automatic add_vec(input logic rs, input logic [15:0] e, input logic r, input logic v,
                           input logic [3:0] i, input logic [15:0] rl, input logic [31:0] c);
        vec_t t;
        t.rst = rs; t.en = e; t.rdy = r; t.val = v; t.iid = i; t.rel = rl; t.cnt = c;
        vecs.push_back(t);
    endtask

    initial begin
        int exp_next;
        int hs;

        rst_n = 1'b0;
        en    = '0;
        rdy   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Idle after reset.
        add_vec(1, 16'h0000, 0, 0, 0, 16'h0000, 0);
        for (int i = 0; i < 4; i++) add_vec(0, 16'h0000, 0, 0, 0, 16'h0000, 0);
        // Single release of IID 4.
        add_vec(0, 16'h0010, 1, 0, 0, 16'h0000, 0);
        add_vec(0, 16'h0000, 1, 1, 4, 16'h0010, 0);
        add_vec(0, 16'h0000, 0, 0, 0, 16'h0000, 1);
        // Back-to-back 0, 1, 15 from rr=0.
        add_vec(1, 16'h8003, 1, 0, 0, 16'h0000, 0);
        add_vec(0, 16'h8003, 1, 1, 0, 16'h0001, 0);
        add_vec(0, 16'h8003, 1, 1, 1, 16'h0002, 1);
        add_vec(0, 16'h0000, 1, 1, 15, 16'h8000, 2);
        add_vec(0, 16'h0000, 0, 0, 0, 16'h0000, 3);
        // Stalled offer of IID 5 survives its enable dropping.
        add_vec(0, 16'h0020, 0, 0, 0, 16'h0000, 3);
        add_vec(0, 16'h0020, 0, 1, 5, 16'h0000, 3);
        add_vec(0, 16'h0000, 0, 1, 5, 16'h0000, 3);
        add_vec(0, 16'h0000, 0, 1, 5, 16'h0000, 3);
        add_vec(0, 16'h0000, 0, 1, 5, 16'h0000, 3);
        add_vec(0, 16'h0000, 1, 1, 5, 16'h0020, 3);
        add_vec(0, 16'h0000, 0, 0, 0, 16'h0000, 4);

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            en  = vecs[k].en;
            rdy = vecs[k].rdy;
            #4;
            chk($sformatf("vec%0d.valid", k), {31'h0, valid}, {31'h0, vecs[k].val});
            if (vecs[k].val) chk($sformatf("vec%0d.iid", k), {28'h0, offer_iid}, {28'h0, vecs[k].iid});
            chk($sformatf("vec%0d.released", k), {16'h0, rel_oh}, {16'h0, vecs[k].rel});
            chk($sformatf("vec%0d.cnt", k), cnt, vecs[k].cnt);
            check_model($sformatf("vec%0d.model", k));
            @(posedge clk);
            model_clock(vecs[k].en, vecs[k].rdy);
            #1;
        end

        // All-ones enable, ready toggling: strict in-order service with wrap.
        do_reset();
        exp_next = 0;
        hs       = 0;
        for (int i = 0; i < 40; i++) begin
            en  = 16'hFFFF;
            rdy = (i % 2 == 0);
            #4;
            if (valid && rdy) begin
                chk("rr_order", {28'h0, offer_iid}, exp_next);
                exp_next = (exp_next + 1) % Capa;
                hs++;
            end
            check_model("ffff");
            @(posedge clk);
            model_clock(16'hFFFF, (i % 2 == 0));
            #1;
        end
        chk("rr_wrap_seen", {31'h0, (hs > Capa)}, 1);

        // Reset while offering IID 7, after one accepted release.
        do_reset();
        step(16'h0080, 1, "pre7a");
        step(16'h0080, 1, "pre7b");
        step(16'h0080, 0, "pre7c");
        en  = 16'h0080;
        rdy = 1'b0;
        #1;
        chk("pre_rst.valid", {31'h0, valid}, 1);
        chk("pre_rst.iid", {28'h0, offer_iid}, 7);
        chk("pre_rst.cnt", cnt, 1);
        rst_n = 1'b0;
        rdy   = 1'b1;
        #1;
        chk("mid_rst.valid", {31'h0, valid}, 0);
        chk("mid_rst.released", {16'h0, rel_oh}, 0);
        chk("mid_rst.cnt", cnt, 0);
        chk("mid_rst.iid", {28'h0, offer_iid}, 0);
        @(posedge clk);
        #1;
        chk("in_rst.valid", {31'h0, valid}, 0);
        rst_n = 1'b1;
        model_reset();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] e;
            int sel;
            sel = $urandom_range(0, 3);
            if (sel == 0) e = 16'h0;
            else if (sel == 1) e = 16'($urandom);
            else e = 16'($urandom) & 16'($urandom) & 16'($urandom);
            step(e, ($urandom_range(0, 2) != 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/simmem_release_scheduler.md
Name: simmem_release_scheduler

Overview:
- Sits between the delay calculator and one response bank (write-response or read-data).
- Turns the multi-hot release-enable vector into a sequence of single releases, one IID at a time.
- Uses round-robin arbitration and a stable valid/ready offer.
- Returns a one-hot released-IID confirmation to the delay calculator on every accepted release, and counts releases.

Parameters:
- Capa, 16, number of IIDs in the served bank; power of two, ≥2.
- IidW, $clog2(Capa), width of the binary IID.
- CntW, 32, width of the release statistics counter.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- release_en_mhot_i  input  Capa  IIDs whose delay has elapsed and may be released.
- rsp_ready_i  input  1  bank accepts the offered release.
- rsp_valid_o  output  1  a release is offered.
- release_iid_onehot_o  output  Capa  one-hot IID being offered.
- release_iid_o  output  IidW  binary form of the offered IID.
- released_iid_onehot_o  output  Capa  one-hot confirmation to the delay calculator; pulses on handshake.
- release_cnt_o  output  CntW  total accepted releases since reset.

Behaviour:
- One clock, clk_i; reset is asynchronous on rst_ni low (active-low).
- Reset values:
  - rsp_valid_o=0, release_iid_onehot_o=0, release_iid_o=0.
  - released_iid_onehot_o=0, release_cnt_o=0.
  - round-robin pointer rr_q=0, state IDLE.
- State IDLE:
  - rsp_valid_o=0.
  - If any bit of eligible = release_en_mhot_i is set: pick the first set bit at index ≥ rr_q, wrapping Capa-1→0.
  - Register the pick into grant_q and go to OFFER. The offer appears one cycle after the enable is seen.
- State OFFER:
  - rsp_valid_o=1; release_iid_onehot_o=grant_q; release_iid_o=binary(grant_q).
  - Outputs are held stable until rsp_ready_i=1.
  - The offer is never retracted. If the granted bit of release_en_mhot_i drops mid-offer, the offer remains.
- Handshake (rsp_valid_o && rsp_ready_i):
  - released_iid_onehot_o=grant_q in the same cycle (combinational from handshake); zero otherwise.
  - release_cnt_o increments next cycle and wraps at 2^CntW.
  - rr_q <= granted index+1, mod Capa.
  - Eligibility for the next pick = release_en_mhot_i & ~grant_q. The just-released IID is excluded even if still asserted this cycle.
  - If eligible≠0: pick the next IID starting from granted index+1 and stay in OFFER. Back-to-back releases are allowed, one per cycle.
  - Else go to IDLE.
- Fairness:
  - With N enabled IIDs continuously asserted, each is released within N handshakes.
  - No IID waits more than Capa-1 other releases.
- rsp_ready_i while in IDLE is ignored.
- All-ones enable: IIDs rr_q, rr_q+1, … are released in order with wrap.
- Reset mid-offer: all state returns to reset values immediately. No confirmation pulse is generated.
- The arbiter search is purely combinational over Capa bits. No multi-cycle search.

Test Plan:
- Reset, then en=16'h0000 for 5 cycles -> rsp_valid_o=0, confirmation 0, release_cnt_o=0.
- en=16'h0010 one cycle after reset, rsp_ready_i=1 -> rsp_valid_o=1 next cycle with release_iid_o=4; released_iid_onehot_o=16'h0010 that cycle; release_cnt_o=1 next cycle; then IDLE.
- en=16'h8003 held, rsp_ready_i=1, rr_q=0 -> releases IID 0, 1, 15 on consecutive cycles; release_cnt_o=3.
- en=16'h0020, rsp_ready_i low for 4 cycles with en dropping to 0 after 1 cycle -> offer IID 5 held stable all 4 cycles. Confirmation 16'h0020 only on the ready cycle.
- en=16'hFFFF held, ready toggling 1,0,1,… -> IIDs 0..15 released in order, each exactly once per 16 handshakes; wrap to 0 after 15.
- Assert rst_ni=0 while offering IID 7 -> rsp_valid_o=0 asynchronously, no confirmation pulse, release_cnt_o=0.
